// File: rtl/spi_controller.sv
// Mode-0 SPI master: shifts one WIDTH-bit word out on mosi (MSB first) while
// capturing WIDTH bits from miso, with sclk/cs_n derived from clk.
//
// state | meaning
// IDLE  | waiting for start; cs_n high, sclk low
// SETUP | cs_n low, first bit on mosi, waiting for the first rising edge
// HIGH  | sclk high; miso was captured on entry
// LOW   | sclk low; next tx bit was put on mosi on entry
// HOLD  | cs_n high after the last bit; rxData is presented on exit
module spi_controller #(
   parameter int WIDTH  = 8,
   parameter int CLKDIV = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] txData,
   output logic [WIDTH-1:0] rxData,
   output logic             busy,
   output logic             done,
   output logic             sclk,
   output logic             cs_n,
   output logic             mosi,
   input  logic             miso
);

   localparam int DIVW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int BITW = $clog2(WIDTH);
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLKDIV - 1);
   localparam logic [BITW-1:0] BIT_LAST = BITW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      HIGH  = 3'd2,
      LOW   = 3'd3,
      HOLD  = 3'd4
   } state_t;

   state_t           state, stateNext;
   logic [DIVW-1:0]  divCnt, divCntNext;
   logic [BITW-1:0]  bitCnt, bitCntNext;
   // The MSB goes straight from txData to mosi, so only the lower bits are kept.
   logic [WIDTH-2:0] txShift, txShiftNext;
   logic [WIDTH-1:0] rxShift, rxShiftNext;
   logic [WIDTH-1:0] rxDataNext;
   logic             sclkNext, csNNext, mosiNext, busyNext, doneNext;
   logic             divTerm;

   assign divTerm = (divCnt == DIV_LAST);

   always_comb begin
      stateNext   = state;
      divCntNext  = (state == IDLE || divTerm) ? '0 : divCnt + DIVW'(1);
      bitCntNext  = bitCnt;
      txShiftNext = txShift;
      rxShiftNext = rxShift;
      rxDataNext  = rxData;
      sclkNext    = sclk;
      csNNext     = cs_n;
      mosiNext    = mosi;
      busyNext    = busy;
      doneNext    = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               stateNext   = SETUP;
               txShiftNext = txData[WIDTH-2:0];
               rxShiftNext = '0;
               bitCntNext  = '0;
               csNNext     = 1'b0;
               mosiNext    = txData[WIDTH-1];
               busyNext    = 1'b1;
            end
         end
         SETUP: begin
            if (divTerm) begin
               stateNext   = HIGH;
               sclkNext    = 1'b1;
               rxShiftNext = {rxShift[WIDTH-2:0], miso};
            end
         end
         HIGH: begin
            if (divTerm) begin
               stateNext = LOW;
               sclkNext  = 1'b0;
               if (bitCnt != BIT_LAST) begin
                  mosiNext    = txShift[WIDTH-2];
                  txShiftNext = txShift << 1;
               end
            end
         end
         LOW: begin
            if (divTerm) begin
               if (bitCnt == BIT_LAST) begin
                  stateNext  = HOLD;
                  bitCntNext = '0;
                  csNNext    = 1'b1;
                  mosiNext   = 1'b0;
               end else begin
                  stateNext   = HIGH;
                  bitCntNext  = bitCnt + BITW'(1);
                  sclkNext    = 1'b1;
                  rxShiftNext = {rxShift[WIDTH-2:0], miso};
               end
            end
         end
         HOLD: begin
            if (divTerm) begin
               stateNext  = IDLE;
               rxDataNext = rxShift;
               doneNext   = 1'b1;
               busyNext   = 1'b0;
            end
         end
         default: begin
            stateNext = IDLE;
            sclkNext  = 1'b0;
            csNNext   = 1'b1;
            mosiNext  = 1'b0;
            busyNext  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         divCnt  <= '0;
         bitCnt  <= '0;
         txShift <= '0;
         rxShift <= '0;
         rxData  <= '0;
         sclk    <= 1'b0;
         cs_n    <= 1'b1;
         mosi    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= stateNext;
         divCnt  <= divCntNext;
         bitCnt  <= bitCntNext;
         txShift <= txShiftNext;
         rxShift <= rxShiftNext;
         rxData  <= rxDataNext;
         sclk    <= sclkNext;
         cs_n    <= csNNext;
         mosi    <= mosiNext;
         busy    <= busyNext;
         done    <= doneNext;
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller (WIDTH=8, CLKDIV=2): table of frames checked cycle by
// cycle against a timing model, plus hand-written reset/back-to-back sequences.
module tb_spi_controller;

   localparam int W = 8;
   localparam int D = 2;
   localparam int FRAME = (2 * W + 2) * D;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] txData = '0;
   logic [W-1:0] rxData;
   logic         busy, done, sclk, cs_n, mosi, miso;

   int           misoMode = 0;
   logic [W-1:0] periph;
   logic         periphLoad = 1'b0;
   logic [W-1:0] prevRx = '0;

   int nChecks = 0;
   int nFail   = 0;

   typedef struct {
      logic [W-1:0] tx;
      int           mode;
      logic [W-1:0] expRx;
      logic [W-1:0] expPeriph;
      int           injAt;
   } vec_t;

   vec_t vecs[7];

   spi_controller #(.WIDTH(W), .CLKDIV(D)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (start),
      .txData (txData),
      .rxData (rxData),
      .busy   (busy),
      .done   (done),
      .sclk   (sclk),
      .cs_n   (cs_n),
      .mosi   (mosi),
      .miso   (miso)
   );

   always #5 clk = ~clk;

   // 0: loopback, 1: tied high, 2: shiftregister peripheral, 3: tied low
   always_comb begin
      case (misoMode)
         0:       miso = mosi;
         1:       miso = 1'b1;
         2:       miso = periph[W-1];
         default: miso = 1'b0;
      endcase
   end

   always @(posedge sclk or posedge periphLoad) begin
      if (periphLoad) periph <= 8'h3B;
      else if (!cs_n) periph <= {periph[W-2:0], mosi};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic runFrame(input logic [W-1:0] tx, input logic [W-1:0] expRx, input int injAt);
      int f;
      int doneCnt;
      logic expSclk, expMosi;
      doneCnt = 0;
      @(negedge clk);
      txData = tx;
      start  = 1'b1;
      @(posedge clk);
      for (int n = 0; n <= FRAME + 1; n++) begin
         @(negedge clk);
         if (n == 0) start = 1'b0;
         f = n / (2 * D);
         if (f > W - 1) f = W - 1;
         expSclk = (n >= D) && (n < (2 * W + 1) * D) && (((n / D) % 2) == 1);
         expMosi = (n < (2 * W + 1) * D) ? tx[W-1-f] : 1'b0;
         check($sformatf("tx%0h n%0d cs_n", tx, n), cs_n, (n < (2 * W + 1) * D) ? 0 : 1);
         check($sformatf("tx%0h n%0d sclk", tx, n), sclk, expSclk);
         check($sformatf("tx%0h n%0d mosi", tx, n), mosi, expMosi);
         check($sformatf("tx%0h n%0d busy", tx, n), busy, (n < FRAME) ? 1 : 0);
         check($sformatf("tx%0h n%0d done", tx, n), done, (n == FRAME) ? 1 : 0);
         check($sformatf("tx%0h n%0d rxData", tx, n), rxData, (n >= FRAME) ? expRx : prevRx);
         if (done) doneCnt++;
         if (injAt > 0 && n == injAt - 1) begin
            start  = 1'b1;
            txData = '0;
         end
         if (injAt > 0 && n == injAt) start = 1'b0;
      end
      check($sformatf("tx%0h done count", tx), doneCnt, 1);
      prevRx = expRx;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int doneCnt, done1, done2, csHigh;

      vecs[0] = '{tx: 8'hA5, mode: 0, expRx: 8'hA5, expPeriph: 8'h00, injAt: 0};
      vecs[1] = '{tx: 8'h00, mode: 1, expRx: 8'hFF, expPeriph: 8'h00, injAt: 0};
      vecs[2] = '{tx: 8'h92, mode: 2, expRx: 8'h3B, expPeriph: 8'h92, injAt: 0};
      vecs[3] = '{tx: 8'hA5, mode: 0, expRx: 8'hA5, expPeriph: 8'h00, injAt: 10};
      vecs[4] = '{tx: 8'h3C, mode: 0, expRx: 8'h3C, expPeriph: 8'h00, injAt: 0};
      vecs[5] = '{tx: 8'hFF, mode: 3, expRx: 8'h00, expPeriph: 8'h00, injAt: 0};
      vecs[6] = '{tx: 8'hC3, mode: 1, expRx: 8'hFF, expPeriph: 8'h00, injAt: 0};

      // Reset held for 3 edges with start asserted
      reset_n = 1'b0;
      start   = 1'b1;
      txData  = 8'hA5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset sclk", sclk, 0);
      check("reset cs_n", cs_n, 1);
      check("reset mosi", mosi, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset rxData", rxData, 0);
      reset_n = 1'b1;
      start   = 1'b0;
      prevRx  = '0;

      for (int i = 0; i < 7; i++) begin
         misoMode = vecs[i].mode;
         if (vecs[i].mode == 2) begin
            @(negedge clk);
            #1 periphLoad = 1'b1;
            #1 periphLoad = 1'b0;
            check("periph preload", periph, 8'h3B);
         end
         runFrame(vecs[i].tx, vecs[i].expRx, vecs[i].injAt);
         if (vecs[i].mode == 2) check("periph parallelDataOut", periph, vecs[i].expPeriph);
      end

      // start held high: back-to-back frames with one IDLE cycle between
      misoMode = 0;
      doneCnt  = 0;
      done1    = -1;
      done2    = -1;
      csHigh   = 0;
      @(negedge clk);
      txData = 8'h5C;
      start  = 1'b1;
      @(posedge clk);
      for (int n = 0; n <= 80; n++) begin
         @(negedge clk);
         if (n == 40) start = 1'b0;
         if (done) begin
            doneCnt++;
            if (done1 < 0) done1 = n;
            else if (done2 < 0) done2 = n;
         end
         if (n > 0 && n < 71 && cs_n) csHigh++;
      end
      check("b2b done count", doneCnt, 2);
      check("b2b first done", done1, FRAME);
      check("b2b second done", done2, 2 * FRAME + 1);
      check("b2b cs_n high gap", csHigh, D + 1);
      check("b2b rxData", rxData, 8'h5C);
      prevRx = 8'h5C;

      // Reset in the middle of a frame
      @(negedge clk);
      txData = 8'hA5;
      start  = 1'b1;
      @(posedge clk);
      for (int n = 0; n <= 20; n++) begin
         @(negedge clk);
         if (n == 0) start = 1'b0;
         if (n == 15) begin
            check("midreset cs_n", cs_n, 1);
            check("midreset sclk", sclk, 0);
            check("midreset busy", busy, 0);
            check("midreset mosi", mosi, 0);
            check("midreset rxData", rxData, 0);
         end
         if (n >= 15) check($sformatf("midreset n%0d done", n), done, 0);
         if (n == 14) reset_n = 1'b0;
         if (n == 20) reset_n = 1'b1;
      end
      prevRx = '0;
      runFrame(8'h5A, 8'h5A, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
